soc_reset_seq: RTL and testbench

SOC_RESET_SEQ -- requirements
Module: soc_reset_seq

---
 rtl/soc_reset_seq.sv | 219 +++++++++++++++++++++
 tb/tb_soc_reset_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_reset_seq.sv
// rtl/soc_reset_seq.sv - PLL lock supervision with staged, filtered domain reset release

// Two-flop synchroniser with asynchronous clear; the output is never used before the second flop
module soc_reset_seq_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   // capture stage then stable stage; both flops clear immediately on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module soc_reset_seq #(
   parameter int NUM_PLL        = 1,
   parameter int NUM_DOMAINS    = 2,
   parameter int LOCK_FILTER    = 16,
   parameter int PLL_RST_CYCLES = 4,
   parameter int STAGE_DELAY    = 8,
   parameter int LOCK_TIMEOUT   = 65535
) (
   input  logic                   io_systemClk,
   input  logic                   io_asyncReset,
   input  logic [NUM_PLL-1:0]     pll_locked,
   input  logic                   sw_reset_req,
   output logic [NUM_PLL-1:0]     pll_rstn,
   output logic [NUM_DOMAINS-1:0] domain_rstn,
   output logic                   mcu_reset,
   output logic                   all_locked,
   output logic                   timeout_err,
   output logic [3:0]             retry_count
);
   localparam int STAGE_TOTAL = STAGE_DELAY * NUM_DOMAINS;
   // counters hold 0..MAX-1 and leave their state before reaching MAX, so clog2(MAX) bits suffice
   localparam int PRW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
   localparam int FLW = (LOCK_FILTER    > 1) ? $clog2(LOCK_FILTER)    : 1;
   localparam int TOW = (LOCK_TIMEOUT   > 1) ? $clog2(LOCK_TIMEOUT)   : 1;
   localparam int STW = (STAGE_TOTAL    > 1) ? $clog2(STAGE_TOTAL)    : 1;

   typedef enum logic [1:0] {
      ST_PLL_RST   = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   logic               rst_n;
   logic [NUM_PLL-1:0] lock_sync;
   logic               lk;

   state_t                 state, state_nxt;
   logic [PRW-1:0]         prst_cnt, prst_nxt;
   logic [FLW-1:0]         filt_cnt, filt_nxt;
   logic [TOW-1:0]         tmo_cnt, tmo_nxt;
   logic [STW-1:0]         stage_cnt, stage_nxt;
   logic                   pll_run, pll_run_nxt;
   logic [NUM_DOMAINS-1:0] dom_nxt;
   logic                   locked_nxt;
   logic                   terr_nxt;
   logic [3:0]             retry_nxt;

   // reset asserts asynchronously and releases two clocks later, clean on io_systemClk
   soc_reset_seq_sync #(.WIDTH(1)) u_rst_sync (
      .clk   (io_systemClk),
      .rst_n (io_asyncReset),
      .d     (1'b1),
      .q     (rst_n)
   );

   // raw lock flags come from the PLLs' own domains
   soc_reset_seq_sync #(.WIDTH(NUM_PLL)) u_lock_sync (
      .clk   (io_systemClk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_sync)
   );

   assign lk        = &lock_sync;
   assign pll_rstn  = {NUM_PLL{pll_run}};
   assign mcu_reset = ~domain_rstn[0];

   // state, counters and all registered outputs
   always_ff @(posedge io_systemClk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PLL_RST;
         prst_cnt    <= '0;
         filt_cnt    <= '0;
         tmo_cnt     <= '0;
         stage_cnt   <= '0;
         pll_run     <= 1'b0;
         domain_rstn <= '0;
         all_locked  <= 1'b0;
         timeout_err <= 1'b0;
         retry_count <= 4'd0;
      end else begin
         state       <= state_nxt;
         prst_cnt    <= prst_nxt;
         filt_cnt    <= filt_nxt;
         tmo_cnt     <= tmo_nxt;
         stage_cnt   <= stage_nxt;
         pll_run     <= pll_run_nxt;
         domain_rstn <= dom_nxt;
         all_locked  <= locked_nxt;
         timeout_err <= terr_nxt;
         retry_count <= retry_nxt;
      end
   end

   // next-state and next-output decode; lock loss outranks a software request
   always_comb begin
      state_nxt   = state;
      prst_nxt    = prst_cnt;
      filt_nxt    = filt_cnt;
      tmo_nxt     = tmo_cnt;
      stage_nxt   = stage_cnt;
      pll_run_nxt = pll_run;
      dom_nxt     = domain_rstn;
      locked_nxt  = all_locked;
      terr_nxt    = timeout_err;
      retry_nxt   = retry_count;

      case (state)
         ST_PLL_RST: begin
            pll_run_nxt = 1'b0;
            dom_nxt     = '0;
            locked_nxt  = 1'b0;
            if (prst_cnt == PRW'(PLL_RST_CYCLES - 1)) begin
               state_nxt   = ST_WAIT_LOCK;
               pll_run_nxt = 1'b1;
               filt_nxt    = '0;
               tmo_nxt     = '0;
            end else begin
               prst_nxt = prst_cnt + 1'b1;
            end
         end

         ST_WAIT_LOCK: begin
            dom_nxt = '0;
            if (lk && (filt_cnt == FLW'(LOCK_FILTER - 1))) begin
               // this cycle completes the run of consecutive locked cycles
               state_nxt  = ST_RELEASE;
               locked_nxt = 1'b1;
               stage_nxt  = '0;
            end else if (tmo_cnt == TOW'(LOCK_TIMEOUT - 1)) begin
               state_nxt   = ST_PLL_RST;
               pll_run_nxt = 1'b0;
               prst_nxt    = '0;
               terr_nxt    = 1'b1;
               if (retry_count != 4'd15) begin
                  retry_nxt = retry_count + 4'd1;
               end
            end else begin
               tmo_nxt  = tmo_cnt + 1'b1;
               filt_nxt = lk ? (filt_cnt + 1'b1) : '0;
            end
         end

         ST_RELEASE: begin
            if (!lk) begin
               state_nxt   = ST_PLL_RST;
               pll_run_nxt = 1'b0;
               prst_nxt    = '0;
               dom_nxt     = '0;
               locked_nxt  = 1'b0;
            end else if (sw_reset_req) begin
               dom_nxt   = '0;
               stage_nxt = '0;
            end else begin
               // domain k opens on the edge that ends cycle STAGE_DELAY*(k+1) of the staging
               for (int k = 0; k < NUM_DOMAINS; k++) begin
                  if (stage_cnt == STW'(STAGE_DELAY * (k + 1) - 1)) begin
                     dom_nxt[k] = 1'b1;
                  end
               end
               if (stage_cnt == STW'(STAGE_TOTAL - 1)) begin
                  state_nxt = ST_RUN;
               end else begin
                  stage_nxt = stage_cnt + 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (!lk) begin
               state_nxt   = ST_PLL_RST;
               pll_run_nxt = 1'b0;
               prst_nxt    = '0;
               dom_nxt     = '0;
               locked_nxt  = 1'b0;
            end else if (sw_reset_req) begin
               // PLLs stay up; only the domains go back through staging
               state_nxt = ST_RELEASE;
               dom_nxt   = '0;
               stage_nxt = '0;
            end
         end

         default: begin
            state_nxt   = ST_PLL_RST;
            pll_run_nxt = 1'b0;
            prst_nxt    = '0;
            dom_nxt     = '0;
            locked_nxt  = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_soc_reset_seq.sv
// tb/tb_soc_reset_seq.sv - directed self-checking bench for soc_reset_seq
module tb_soc_reset_seq;
   logic       clk = 1'b0;
   logic       arst_n;
   logic [2:0] locked;
   logic       sw;
   logic [2:0] pll_rstn;
   logic [1:0] domain_rstn;
   logic       mcu_reset;
   logic       all_locked;
   logic       timeout_err;
   logic [3:0] retry_count;

   int checks   = 0;
   int failures = 0;

   soc_reset_seq #(
      .NUM_PLL      (3),
      .NUM_DOMAINS  (2),
      .LOCK_FILTER  (16),
      .PLL_RST_CYCLES(4),
      .STAGE_DELAY  (8),
      .LOCK_TIMEOUT (100)
   ) dut (
      .io_systemClk (clk),
      .io_asyncReset(arst_n),
      .pll_locked   (locked),
      .sw_reset_req (sw),
      .pll_rstn     (pll_rstn),
      .domain_rstn  (domain_rstn),
      .mcu_reset    (mcu_reset),
      .all_locked   (all_locked),
      .timeout_err  (timeout_err),
      .retry_count  (retry_count)
   );

   // free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // leaves the bench 1 time unit after the edge on which the internal reset releases
   task automatic apply_reset;
      sw = 1'b0;
      locked = 3'b000;
      #2 arst_n = 1'b0;
      tick(3);
      arst_n = 1'b1;
      tick(2);
   endtask

   // reaches RUN with both domains released, 1 unit after the releasing edge
   task automatic bring_up;
      apply_reset;
      locked = 3'b111;
      tick(36);
   endtask

   task automatic test_reset;
      sw = 1'b0;
      locked = 3'b000;
      #2 arst_n = 1'b0;
      #1;
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL rst_pll_rstn got=%b exp=000", pll_rstn); end
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL rst_domain_rstn got=%b exp=00", domain_rstn); end
      checks++; if (mcu_reset !== 1'b1) begin failures++; $display("FAIL rst_mcu_reset got=%b exp=1", mcu_reset); end
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL rst_all_locked got=%b exp=0", all_locked); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout_err got=%b exp=0", timeout_err); end
      checks++; if (retry_count !== 4'd0) begin failures++; $display("FAIL rst_retry_count got=%0d exp=0", retry_count); end
      tick(3);
      arst_n = 1'b1;
      tick(2);
      tick(3);
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL rst_pll_pulse_c3 got=%b exp=000", pll_rstn); end
      tick(1);
      checks++; if (pll_rstn !== 3'b111) begin failures++; $display("FAIL rst_pll_pulse_c4 got=%b exp=111", pll_rstn); end
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL rst_dom_wait got=%b exp=00", domain_rstn); end
   endtask

   task automatic test_default;
      apply_reset;
      tick(10);
      locked = 3'b111;
      tick(17);
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL def_all_locked_early got=%b exp=0", all_locked); end
      tick(1);
      checks++; if (all_locked !== 1'b1) begin failures++; $display("FAIL def_all_locked got=%b exp=1", all_locked); end
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL def_dom_at_lock got=%b exp=00", domain_rstn); end
      tick(7);
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL def_dom_7 got=%b exp=00", domain_rstn); end
      tick(1);
      checks++; if (domain_rstn !== 2'b01) begin failures++; $display("FAIL def_dom_8 got=%b exp=01", domain_rstn); end
      checks++; if (mcu_reset !== 1'b0) begin failures++; $display("FAIL def_mcu_8 got=%b exp=0", mcu_reset); end
      tick(7);
      checks++; if (domain_rstn !== 2'b01) begin failures++; $display("FAIL def_dom_15 got=%b exp=01", domain_rstn); end
      tick(1);
      checks++; if (domain_rstn !== 2'b11) begin failures++; $display("FAIL def_dom_16 got=%b exp=11", domain_rstn); end
   endtask

   task automatic test_glitch;
      apply_reset;
      locked = 3'b111;
      tick(14);
      locked = 3'b000;
      tick(1);
      locked = 3'b111;
      tick(5);
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL glitch_unfiltered_point got=%b exp=0", all_locked); end
      tick(12);
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL glitch_before got=%b exp=0", all_locked); end
      tick(1);
      checks++; if (all_locked !== 1'b1) begin failures++; $display("FAIL glitch_release got=%b exp=1", all_locked); end
   endtask

   task automatic test_lock_loss;
      bring_up;
      checks++; if (domain_rstn !== 2'b11) begin failures++; $display("FAIL loss_run got=%b exp=11", domain_rstn); end
      locked = 3'b000;
      tick(2);
      checks++; if (domain_rstn !== 2'b11) begin failures++; $display("FAIL loss_c2 got=%b exp=11", domain_rstn); end
      tick(1);
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL loss_dom_c3 got=%b exp=00", domain_rstn); end
      checks++; if (mcu_reset !== 1'b1) begin failures++; $display("FAIL loss_mcu_c3 got=%b exp=1", mcu_reset); end
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL loss_locked_c3 got=%b exp=0", all_locked); end
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL loss_pll_c3 got=%b exp=000", pll_rstn); end
      tick(3);
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL loss_pll_c6 got=%b exp=000", pll_rstn); end
      tick(1);
      checks++; if (pll_rstn !== 3'b111) begin failures++; $display("FAIL loss_pll_c7 got=%b exp=111", pll_rstn); end
   endtask

   task automatic test_sw_reset;
      bring_up;
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL sw_dom_next got=%b exp=00", domain_rstn); end
      checks++; if (pll_rstn !== 3'b111) begin failures++; $display("FAIL sw_pll got=%b exp=111", pll_rstn); end
      checks++; if (all_locked !== 1'b1) begin failures++; $display("FAIL sw_locked got=%b exp=1", all_locked); end
      tick(7);
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL sw_dom_7 got=%b exp=00", domain_rstn); end
      tick(1);
      checks++; if (domain_rstn !== 2'b01) begin failures++; $display("FAIL sw_dom_8 got=%b exp=01", domain_rstn); end
      tick(8);
      checks++; if (domain_rstn !== 2'b11) begin failures++; $display("FAIL sw_dom_16 got=%b exp=11", domain_rstn); end
      checks++; if (pll_rstn !== 3'b111) begin failures++; $display("FAIL sw_pll_16 got=%b exp=111", pll_rstn); end
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      tick(4);
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL sw2_dom got=%b exp=00", domain_rstn); end
      tick(3);
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL sw2_old_stage got=%b exp=00", domain_rstn); end
      tick(4);
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL sw2_dom_7 got=%b exp=00", domain_rstn); end
      tick(1);
      checks++; if (domain_rstn !== 2'b01) begin failures++; $display("FAIL sw2_dom_8 got=%b exp=01", domain_rstn); end
      tick(8);
      checks++; if (domain_rstn !== 2'b11) begin failures++; $display("FAIL sw2_dom_16 got=%b exp=11", domain_rstn); end
   endtask

   task automatic test_priority;
      bring_up;
      locked = 3'b000;
      tick(2);
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL prio_pll got=%b exp=000", pll_rstn); end
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL prio_locked got=%b exp=0", all_locked); end
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL prio_dom got=%b exp=00", domain_rstn); end
   endtask

   task automatic test_async_mid_release;
      apply_reset;
      locked = 3'b101;
      tick(40);
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL part_locked got=%b exp=0", all_locked); end
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL part_dom got=%b exp=00", domain_rstn); end
      locked = 3'b111;
      tick(18);
      checks++; if (all_locked !== 1'b1) begin failures++; $display("FAIL mid_locked got=%b exp=1", all_locked); end
      tick(8);
      checks++; if (domain_rstn !== 2'b01) begin failures++; $display("FAIL mid_dom got=%b exp=01", domain_rstn); end
      #2 arst_n = 1'b0;
      #1;
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL mid_rst_dom got=%b exp=00", domain_rstn); end
      checks++; if (mcu_reset !== 1'b1) begin failures++; $display("FAIL mid_rst_mcu got=%b exp=1", mcu_reset); end
      checks++; if (all_locked !== 1'b0) begin failures++; $display("FAIL mid_rst_locked got=%b exp=0", all_locked); end
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL mid_rst_pll got=%b exp=000", pll_rstn); end
      tick(1);
   endtask

   task automatic test_timeout;
      apply_reset;
      tick(48);
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      checks++; if (domain_rstn !== 2'b00) begin failures++; $display("FAIL to_sw_ignored got=%b exp=00", domain_rstn); end
      tick(54);
      checks++; if (pll_rstn !== 3'b111) begin failures++; $display("FAIL to_pll_before got=%b exp=111", pll_rstn); end
      checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_err_before got=%b exp=0", timeout_err); end
      tick(1);
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL to_pll_first got=%b exp=000", pll_rstn); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_first got=%b exp=1", timeout_err); end
      checks++; if (retry_count !== 4'd1) begin failures++; $display("FAIL to_retry_first got=%0d exp=1", retry_count); end
      tick(3);
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL to_pulse_c3 got=%b exp=000", pll_rstn); end
      tick(1);
      checks++; if (pll_rstn !== 3'b111) begin failures++; $display("FAIL to_pulse_c4 got=%b exp=111", pll_rstn); end
      tick(1451);
      checks++; if (retry_count !== 4'd14) begin failures++; $display("FAIL to_retry_14 got=%0d exp=14", retry_count); end
      tick(1);
      checks++; if (retry_count !== 4'd15) begin failures++; $display("FAIL to_retry_15 got=%0d exp=15", retry_count); end
      tick(208);
      checks++; if (retry_count !== 4'd15) begin failures++; $display("FAIL to_retry_sat got=%0d exp=15", retry_count); end
      checks++; if (pll_rstn !== 3'b000) begin failures++; $display("FAIL to_pll_17 got=%b exp=000", pll_rstn); end
      checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", timeout_err); end
   endtask

   initial begin
      arst_n = 1'b0;
      locked = 3'b000;
      sw = 1'b0;
      tick(2);
      test_reset;
      test_default;
      test_glitch;
      test_lock_loss;
      test_sw_reset;
      test_priority;
      test_async_mid_release;
      test_timeout;
      test_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
